// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter that shares one multi-cycle ALU (alu1)
// between two requesters. One operation is in flight at a time: it is
// accepted in IDLE, its operands are held on the ALU for ALU_LAT+1 cycles
// in EXEC, and the captured result is strobed back to its owner in RESP.
module alu_arbiter #(
  parameter int ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [3:0]  req0_ctrl,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  logic [3:0]  req1_ctrl,
  output logic        req1_ready,
  output logic [31:0] alu_r1,
  output logic [31:0] alu_r2,
  output logic [3:0]  alu_ctrl,
  input  logic [31:0] alu_out,
  output logic [31:0] resp_data,
  output logic        resp0_valid,
  output logic        resp1_valid
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;      // EXEC cycles remaining after this one
  logic        last_q, last_d;    // requester granted most recently
  logic        gid_q, gid_d;      // owner of the operation in flight
  logic [31:0] r1_q, r1_d;
  logic [31:0] r2_q, r2_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rv0_q, rv0_d;
  logic        rv1_q, rv1_d;

  logic        gnt_any;
  logic        gnt_id;
  logic        hs;

  // Grant: a lone requester wins; with both valid the one not served last wins.
  always_comb begin
    gnt_any    = req0_valid | req1_valid;
    gnt_id     = (req0_valid && req1_valid) ? ~last_q : ~req0_valid;
    req0_ready = (state_q == IDLE) && !rst && gnt_any && !gnt_id;
    req1_ready = (state_q == IDLE) && !rst && gnt_any &&  gnt_id;
    hs         = req0_ready | req1_ready;
  end

  // Next-state: accept in IDLE, count down in EXEC, strobe once in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    gid_d   = gid_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    ctrl_d  = ctrl_q;
    rdata_d = rdata_q;
    rv0_d   = 1'b0;
    rv1_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (hs) begin
          r1_d    = gnt_id ? req1_op1  : req0_op1;
          r2_d    = gnt_id ? req1_op2  : req0_op2;
          ctrl_d  = gnt_id ? req1_ctrl : req0_ctrl;
          gid_d   = gnt_id;
          last_d  = gnt_id;
          cnt_d   = 3'(ALU_LAT);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 3'd0) begin
          // Operands have been stable for ALU_LAT+1 cycles: result is valid now.
          rdata_d = alu_out;
          ctrl_d  = 4'b0000;
          rv0_d   = ~gid_q;
          rv1_d   =  gid_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      last_q  <= 1'b1;
      gid_q   <= 1'b0;
      r1_q    <= 32'd0;
      r2_q    <= 32'd0;
      ctrl_q  <= 4'd0;
      rdata_q <= 32'd0;
      rv0_q   <= 1'b0;
      rv1_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      ctrl_q  <= ctrl_d;
      rdata_q <= rdata_d;
      rv0_q   <= rv0_d;
      rv1_q   <= rv1_d;
    end
  end

  assign alu_r1      = r1_q;
  assign alu_r2      = r2_q;
  assign alu_ctrl    = ctrl_q;
  assign resp_data   = rdata_q;
  // Strobes are masked while reset is held so an aborted RESP never leaks.
  assign resp0_valid = rv0_q & ~rst;
  assign resp1_valid = rv1_q & ~rst;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two lanes (ALU_LAT=1 and ALU_LAT=3) share one random
// stimulus stream; each lane has an alu1 pipeline model and is compared every
// cycle against a transaction-timeline reference model.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        v0, v1;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  c0, c1;

  logic        rdy0 [2];
  logic        rdy1 [2];
  logic        rv0  [2];
  logic        rv1  [2];
  logic [31:0] ar1  [2];
  logic [31:0] ar2  [2];
  logic [3:0]  actl [2];
  logic [31:0] aout [2];
  logic [31:0] rdat [2];

  int n_cmp = 0;
  int n_err = 0;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  function automatic int lat_of(input int lane);
    return (lane == 0) ? 1 : 3;
  endfunction

  // Behaviour of the external alu1.
  function automatic logic [31:0] alu_f(input logic [31:0] x, input logic [31:0] y,
                                        input logic [3:0] c);
    case (c)
      4'd1:    return x + y;
      4'd2:    return x - y;
      4'd3:    return x & y;
      4'd4:    return x | y;
      4'd5:    return x ^ y;
      4'd6:    return x << y[4:0];
      default: return x;
    endcase
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    localparam int LAT = (gi == 0) ? 1 : 3;
    logic [31:0] pipe [LAT];

    alu_arbiter #(.ALU_LAT(LAT)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (v0),
      .req0_op1   (a0),
      .req0_op2   (b0),
      .req0_ctrl  (c0),
      .req0_ready (rdy0[gi]),
      .req1_valid (v1),
      .req1_op1   (a1),
      .req1_op2   (b1),
      .req1_ctrl  (c1),
      .req1_ready (rdy1[gi]),
      .alu_r1     (ar1[gi]),
      .alu_r2     (ar2[gi]),
      .alu_ctrl   (actl[gi]),
      .alu_out    (aout[gi]),
      .resp_data  (rdat[gi]),
      .resp0_valid(rv0[gi]),
      .resp1_valid(rv1[gi])
    );

    // alu1 model: result appears LAT cycles after its inputs.
    always @(posedge clk) begin
      pipe[0] <= alu_f(ar1[gi], ar2[gi], actl[gi]);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign aout[gi] = pipe[LAT-1];
  end

  task automatic chk(input string nm, input int lane, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s lane%0d t=%0t got=%h exp=%h", nm, lane, $time, got, exp);
    end
  endtask

  // Reference model: one record per lane describing the operation in flight
  // as a timeline (handshake cycle + latency) rather than as FSM state.
  int          m_cyc;
  bit          m_active [2];
  int          m_hs     [2];
  bit          m_id     [2];
  bit          m_last   [2];
  logic [31:0] m_op1    [2];
  logic [31:0] m_op2    [2];
  logic [3:0]  m_ctl    [2];
  logic [31:0] m_r1     [2];
  logic [31:0] m_r2     [2];
  logic [31:0] m_rd     [2];

  task automatic model_reset();
    for (int l = 0; l < 2; l++) begin
      m_active[l] = 1'b0;
      m_last[l]   = 1'b1;
      m_r1[l]     = '0;
      m_r2[l]     = '0;
      m_rd[l]     = '0;
      m_ctl[l]    = '0;
    end
  endtask

  // Per-cycle compare against the model, then advance the model over the edge.
  always @(negedge clk) begin
    if (checking) begin
      for (int l = 0; l < 2; l++) begin
        int   lt;
        bit   idle, e_r0, e_r1, e_rv;
        logic [3:0] e_ctl;
        lt    = lat_of(l);
        idle  = !m_active[l] || (m_cyc >= m_hs[l] + lt + 3);
        e_r0  = !rst && idle && v0 && (!v1 || m_last[l]);
        e_r1  = !rst && idle && v1 && (!v0 || !m_last[l]);
        e_ctl = (m_active[l] && m_cyc >= m_hs[l] + 1 && m_cyc <= m_hs[l] + lt + 1)
                ? m_ctl[l] : 4'd0;
        e_rv  = !rst && m_active[l] && (m_cyc == m_hs[l] + lt + 2);
        chk("req0_ready", l, 32'(rdy0[l]), 32'(e_r0));
        chk("req1_ready", l, 32'(rdy1[l]), 32'(e_r1));
        chk("alu_ctrl",   l, 32'(actl[l]), 32'(e_ctl));
        chk("alu_r1",     l, ar1[l], m_r1[l]);
        chk("alu_r2",     l, ar2[l], m_r2[l]);
        chk("resp_data",  l, rdat[l], m_rd[l]);
        chk("resp0_valid", l, 32'(rv0[l]), 32'(e_rv && !m_id[l]));
        chk("resp1_valid", l, 32'(rv1[l]), 32'(e_rv &&  m_id[l]));
        if (rst) begin
          m_active[l] = 1'b0;
          m_last[l]   = 1'b1;
          m_r1[l]     = '0;
          m_r2[l]     = '0;
          m_rd[l]     = '0;
        end else begin
          if (m_active[l] && m_cyc == m_hs[l] + lt + 1)
            m_rd[l] = alu_f(m_op1[l], m_op2[l], m_ctl[l]);
          if (e_r0 || e_r1) begin
            m_active[l] = 1'b1;
            m_hs[l]     = m_cyc;
            m_id[l]     = e_r1;
            m_last[l]   = e_r1;
            m_op1[l]    = e_r1 ? a1 : a0;
            m_op2[l]    = e_r1 ? b1 : b0;
            m_ctl[l]    = e_r1 ? c1 : c0;
            m_r1[l]     = m_op1[l];
            m_r2[l]     = m_op2[l];
          end
        end
      end
      m_cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  int exp_id [2];
  int n_resp [2];

  initial begin
    rst = 1'b1; v0 = 1'b0; v1 = 1'b0;
    a0 = '0; b0 = '0; c0 = '0; a1 = '0; b1 = '0; c1 = '0;
    m_cyc = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checking = 1'b1;
    at_neg();
    chk("rst_ready0", 0, 32'(rdy0[0]), 32'd0);
    chk("rst_resp_data", 1, rdat[1], 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Single add on requester 0.
    v0 = 1'b1; a0 = 32'hF000_0000; b0 = 32'hF000_0066; c0 = 4'b0001;
    at_neg();
    chk("add_ready_T", 0, 32'(rdy0[0]), 32'd1);
    chk("add_ready_T", 1, 32'(rdy0[1]), 32'd1);
    tick(); v0 = 1'b0;
    at_neg();
    chk("add_ctrl_T1", 0, 32'(actl[0]), 32'd1);
    tick(); at_neg();
    chk("add_ctrl_T2", 0, 32'(actl[0]), 32'd1);
    chk("add_rv_T2", 0, 32'(rv0[0]), 32'd0);
    tick(); at_neg();
    chk("add_rv_T3", 0, 32'(rv0[0]), 32'd1);
    chk("add_data_T3", 0, rdat[0], 32'hE000_0066);
    chk("add_ctrl_T3", 0, 32'(actl[0]), 32'd0);
    tick(); at_neg();
    chk("add_rv_T4", 0, 32'(rv0[0]), 32'd0);
    chk("add_ctrl_T4", 1, 32'(actl[1]), 32'd1);
    chk("add_rv_T4", 1, 32'(rv0[1]), 32'd0);
    tick(); at_neg();
    chk("add_rv_T5", 1, 32'(rv0[1]), 32'd1);
    chk("add_data_T5", 1, rdat[1], 32'hE000_0066);

    // Reset, then both requesters held valid: order and fairness.
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    v0 = 1'b1; a0 = 32'd25; b0 = 32'd1; c0 = 4'b0001;
    v1 = 1'b1; a1 = 32'd25; b1 = 32'd2; c1 = 4'b0001;
    for (int l = 0; l < 2; l++) begin exp_id[l] = 0; n_resp[l] = 0; end
    for (int i = 0; i < 48; i++) begin
      at_neg();
      for (int l = 0; l < 2; l++) begin
        if (rv0[l] || rv1[l]) begin
          chk("fair_id", l, 32'(rv1[l]), 32'(exp_id[l]));
          chk("fair_data", l, rdat[l], (exp_id[l] != 0) ? 32'd27 : 32'd26);
          exp_id[l] ^= 1;
          n_resp[l]++;
        end
      end
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;
    chk("fair_count", 0, 32'(n_resp[0]), 32'd12);
    chk("fair_count", 1, 32'(n_resp[1]), 32'd8);
    repeat (8) tick();

    // Reset one cycle after a handshake aborts the operation.
    v0 = 1'b1; a0 = 32'd7; b0 = 32'd8; c0 = 4'b0010;
    tick(); v0 = 1'b0; rst = 1'b1;
    tick(); rst = 1'b0;
    at_neg();
    for (int l = 0; l < 2; l++) begin
      chk("abort_ctrl", l, 32'(actl[l]), 32'd0);
      chk("abort_data", l, rdat[l], 32'd0);
    end
    for (int i = 0; i < 6; i++) begin
      for (int l = 0; l < 2; l++)
        chk("abort_nostrobe", l, 32'(rv0[l] | rv1[l]), 32'd0);
      tick(); at_neg();
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst = ($urandom_range(0, 59) == 0);
      v0  = ($urandom_range(0, 3) != 0);
      v1  = ($urandom_range(0, 3) != 0);
      a0  = $urandom; b0 = $urandom; c0 = 4'($urandom_range(0, 7));
      a1  = $urandom; b1 = $urandom; c1 = 4'($urandom_range(0, 7));
    end
    tick();
    rst = 1'b0; v0 = 1'b0; v1 = 1'b0;
    repeat (8) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
